gray_updown_counter: RTL and testbench

GRAY_UPDOWN_COUNTER -- requirements
Module: gray_updown_counter

---
 rtl/gray_updown_counter.sv | 74 +++++++
 tb/tb_gray_updown_counter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/gray_updown_counter.sv
// Up/down binary counter with registered Gray-code output, optional saturation,
// synchronous load (clamped to MAX) and a registered terminal-count pulse.
module gray_updown_counter #(
  parameter int unsigned     BITS     = 4,
  parameter logic [BITS-1:0] MAX      = {BITS{1'b1}},
  parameter int              SATURATE = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            dir,
  input  logic            load,
  input  logic [BITS-1:0] load_value,
  output logic [BITS-1:0] value,
  output logic [BITS-1:0] gray,
  output logic            at_max,
  output logic            at_min,
  output logic            tc
);

  // Power-up values match the configured FPGA state before the first reset.
  logic [BITS-1:0] value_q = '0;
  logic [BITS-1:0] gray_q  = '0;
  logic            tc_q    = 1'b0;

  logic [BITS-1:0] value_n;
  logic [BITS-1:0] gray_n;
  logic            tc_n;

  always_comb begin
    value_n = value_q;
    tc_n    = 1'b0;
    if (load) begin
      value_n = (load_value > MAX) ? MAX : load_value;
    end else if (en) begin
      if (dir) begin
        if (value_q >= MAX) begin
          value_n = (SATURATE != 0) ? MAX : '0;
          tc_n    = 1'b1;
        end else begin
          value_n = value_q + 1'b1;
        end
      end else begin
        if (value_q == '0) begin
          value_n = (SATURATE != 0) ? '0 : MAX;
          tc_n    = 1'b1;
        end else begin
          value_n = value_q - 1'b1;
        end
      end
    end
    // Gray is derived from the next state so both registers move on the same edge.
    gray_n = value_n ^ (value_n >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
      gray_q  <= '0;
      tc_q    <= 1'b0;
    end else begin
      value_q <= value_n;
      gray_q  <= gray_n;
      tc_q    <= tc_n;
    end
  end

  assign value  = value_q;
  assign gray   = gray_q;
  assign tc     = tc_q;
  assign at_max = (value_q == MAX);
  assign at_min = (value_q == '0);

endmodule

// File: tb/tb_gray_updown_counter.sv
// Directed bench for gray_updown_counter: three instances (full-range wrap,
// MAX=9 wrap, MAX=9 saturate) share stimulus; expectations go through a queue.
module tb_gray_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic       dir = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_value = '0;

  logic [3:0] v_o  [3];
  logic [3:0] g_o  [3];
  logic       mx_o [3];
  logic       mn_o [3];
  logic       tc_o [3];

  int checks = 0;
  int passes = 0;

  // entry = {dut_id[1:0], value[3:0], tc}
  logic [6:0] exp_q[$];

  always #5 clk = ~clk;

  gray_updown_counter #(.BITS(4), .MAX(4'd15), .SATURATE(0)) u_full (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_value(load_value),
    .value(v_o[0]), .gray(g_o[0]), .at_max(mx_o[0]), .at_min(mn_o[0]), .tc(tc_o[0]));

  gray_updown_counter #(.BITS(4), .MAX(4'd9), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_value(load_value),
    .value(v_o[1]), .gray(g_o[1]), .at_max(mx_o[1]), .at_min(mn_o[1]), .tc(tc_o[1]));

  gray_updown_counter #(.BITS(4), .MAX(4'd9), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_value(load_value),
    .value(v_o[2]), .gray(g_o[2]), .at_max(mx_o[2]), .at_min(mn_o[2]), .tc(tc_o[2]));

  task automatic chk(input string tag, input int id, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s dut%0d observed=%0h expected=%0h at %0t", tag, id, obs, exp, $time);
  endtask

  function automatic void expv(input logic [1:0] id, input int v, input logic t);
    logic [3:0] vv;
    vv = v[3:0];
    exp_q.push_back({id, vv, t});
  endfunction

  task automatic check_pending();
    logic [6:0] e;
    int         id;
    logic [3:0] ev;
    logic [3:0] mx;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      id = int'(e[6:5]);
      ev = e[4:1];
      mx = (id == 0) ? 4'd15 : 4'd9;
      chk("value",  id, v_o[id], ev);
      chk("gray",   id, g_o[id], ev ^ (ev >> 1));
      chk("tc",     id, {3'b0, tc_o[id]}, {3'b0, e[0]});
      chk("at_max", id, {3'b0, mx_o[id]}, {3'b0, ev == mx});
      chk("at_min", id, {3'b0, mn_o[id]}, {3'b0, ev == 4'd0});
    end
  endtask

  task automatic step(input logic r, input logic l, input logic [3:0] lv,
                      input logic e, input logic d);
    @(negedge clk);
    rst = r; load = l; load_value = lv; en = e; dir = d;
    @(posedge clk);
    #1;
    check_pending();
  endtask

  task automatic do_reset();
    expv(2'd0, 0, 1'b0); expv(2'd1, 0, 1'b0); expv(2'd2, 0, 1'b0);
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  logic [3:0] prev_gray;
  int         v;

  initial begin
    // Power-up state before any edge
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("powerup_value", i, v_o[i], 4'd0);
      chk("powerup_tc", i, {3'b0, tc_o[i]}, 4'd0);
    end

    // Up-count full range with wrap; gray moves one bit per step
    do_reset();
    prev_gray = g_o[0];
    for (int i = 1; i <= 17; i++) begin
      v = i % 16;
      expv(2'd0, v, v == 0);
      step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      checks++;
      assert ($countones(g_o[0] ^ prev_gray) == 1) passes++;
      else $error("FAIL gray_one_bit dut0 observed=%0h expected_one_bit_from=%0h", g_o[0], prev_gray);
      prev_gray = g_o[0];
    end
    // Idle: hold value, tc clears
    expv(2'd0, 1, 1'b0);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);

    // Down-count with wrap at MAX=9; saturating copy pins at 0 with tc held
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      v = (i % 10 == 0) ? 0 : 10 - (i % 10);
      expv(2'd1, v, v == 9);
      expv(2'd2, 0, 1'b1);
      step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    end

    // Saturation at top: load 7 then count up 5
    expv(2'd1, 7, 1'b0); expv(2'd2, 7, 1'b0);
    step(1'b0, 1'b1, 4'd7, 1'b0, 1'b0);
    begin
      int sv [5] = '{8, 9, 9, 9, 9};
      int st [5] = '{0, 0, 1, 1, 1};
      int wv [5] = '{8, 9, 0, 1, 2};
      int wt [5] = '{0, 0, 1, 0, 0};
      for (int i = 0; i < 5; i++) begin
        expv(2'd2, sv[i], st[i] != 0);
        expv(2'd1, wv[i], wt[i] != 0);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      end
    end

    // Load beats enable and clamps to MAX; reset beats load
    expv(2'd0, 13, 1'b0); expv(2'd1, 9, 1'b0); expv(2'd2, 9, 1'b0);
    step(1'b0, 1'b1, 4'd13, 1'b1, 1'b1);
    chk("gray_clamped_literal", 1, g_o[1], 4'b1101);
    expv(2'd0, 0, 1'b0); expv(2'd1, 0, 1'b0); expv(2'd2, 0, 1'b0);
    step(1'b1, 1'b1, 4'd13, 1'b1, 1'b1);

    // Direction flip and reset mid-run on MAX=9 wrap counter
    for (int i = 1; i <= 5; i++) begin
      expv(2'd1, i, 1'b0);
      step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    end
    for (int i = 4; i >= 2; i--) begin
      expv(2'd1, i, 1'b0);
      step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    end
    expv(2'd1, 0, 1'b0);
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
    expv(2'd1, 1, 1'b0);
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    expv(2'd1, 2, 1'b0);
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    expv(2'd1, 2, 1'b0);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
